// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - PC tracking and taken-branch redirect for the IF/ID/EX pipeline
// Redirect resolves in EX, squashes the two younger instructions and emits the BL link write.
module pc_branch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_AHEAD     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        branch_link,
  input  logic [31:0] InmShifter,
  output logic [31:0] pc_if,
  output logic [31:0] pc_id,
  output logic [31:0] pc_ex,
  output logic        valid_id,
  output logic        valid_ex,
  output logic        flush,
  output logic        lr_we,
  output logic [31:0] lr_data
);

  localparam logic [31:0] PC_AHEAD_W = 32'(PC_AHEAD);

  logic [31:0] pc_if_q, pc_if_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pc_ex_q, pc_ex_d;
  logic        valid_id_q, valid_id_d;
  logic        valid_ex_q, valid_ex_d;
  logic        flush_q, flush_d;
  logic        lr_we_q, lr_we_d;
  logic [31:0] lr_data_q, lr_data_d;

  logic        redirect;
  logic [31:0] target;

  // Only a correct-path instruction in EX may redirect; bubbles and squashed slots are inert.
  assign redirect = branch_taken & valid_ex_q;
  assign target   = (pc_ex_q + PC_AHEAD_W + InmShifter) & ~32'h3;

  always_comb begin
    pc_if_d    = pc_if_q;
    pc_id_d    = pc_id_q;
    pc_ex_d    = pc_ex_q;
    valid_id_d = valid_id_q;
    valid_ex_d = valid_ex_q;
    flush_d    = 1'b0;
    lr_we_d    = 1'b0;
    lr_data_d  = lr_data_q;

    if (redirect) begin
      pc_if_d    = target;
      valid_id_d = 1'b0;
      valid_ex_d = 1'b0;
      flush_d    = 1'b1;
      lr_we_d    = branch_link;
      lr_data_d  = pc_ex_q + 32'd4;
    end else if (stall) begin
      // IF/ID hold while EX receives a bubble.
      pc_ex_d    = pc_id_q;
      valid_ex_d = 1'b0;
    end else begin
      pc_if_d    = pc_if_q + 32'd4;
      pc_id_d    = pc_if_q;
      valid_id_d = 1'b1;
      pc_ex_d    = pc_id_q;
      valid_ex_d = valid_id_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_if_q    <= RESET_VECTOR;
      pc_id_q    <= 32'h0;
      pc_ex_q    <= 32'h0;
      valid_id_q <= 1'b0;
      valid_ex_q <= 1'b0;
      flush_q    <= 1'b0;
      lr_we_q    <= 1'b0;
      lr_data_q  <= 32'h0;
    end else begin
      pc_if_q    <= pc_if_d;
      pc_id_q    <= pc_id_d;
      pc_ex_q    <= pc_ex_d;
      valid_id_q <= valid_id_d;
      valid_ex_q <= valid_ex_d;
      flush_q    <= flush_d;
      lr_we_q    <= lr_we_d;
      lr_data_q  <= lr_data_d;
    end
  end

  assign pc_if    = pc_if_q;
  assign pc_id    = pc_id_q;
  assign pc_ex    = pc_ex_q;
  assign valid_id = valid_id_q;
  assign valid_ex = valid_ex_q;
  assign flush    = flush_q;
  assign lr_we    = lr_we_q;
  assign lr_data  = lr_data_q;

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Program-counter and branch-redirect stage for the pipelined core. It consumes the 32-bit sign-extended, word-shifted branch offset (`InmShifter`) produced by the immediate shifter and computes the branch target. On a taken branch resolved in EX it redirects fetch and squashes the two wrong-path instructions. It also tracks the PC and valid bit of the instructions in IF, ID and EX, and produces the link-register write for branch-with-link.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'h0000_0000, PC loaded on reset.
- `PC_AHEAD`, default 8, read-ahead added to the branch PC (ARM convention: PC+8).

Ports:
- `clk`  in  1  rising-edge clock; the block's only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `stall`  in  1  ID hazard: hold IF/ID and insert a bubble into EX.
- `branch_taken`  in  1  EX-stage branch condition true; honored only when `valid_ex`=1.
- `branch_link`  in  1  taken branch is BL and must write LR; sampled with `branch_taken`.
- `InmShifter`  in  32  two's-complement byte offset from the immediate shifter; bits [1:0] are always 0.
- `pc_if`  out  32  instruction-memory fetch address.
- `pc_id`, `pc_ex`  out  32 each  PC of the instruction in ID / EX.
- `valid_id`, `valid_ex`  out  1 each  the instruction in that stage is on the correct path.
- `flush`  out  1  one-cycle pulse; the decoder discards its IF/ID contents.
- `lr_we`  out  1  link-register write enable, one-cycle pulse.
- `lr_data`  out  32  return address (branch PC + 4).

## Operation
- Registers: `pc_if`, `pc_id`, `valid_id`, `pc_ex`, `valid_ex`, `flush`, `lr_we`, `lr_data`. All outputs are registered.
- Reset values: `pc_if`=RESET_VECTOR. `pc_id`, `pc_ex` and `lr_data` are 0. `valid_id`, `valid_ex`, `flush` and `lr_we` are 0.
- Reset overrides every other input and takes effect on the next edge, including reset asserted mid-redirect.
- Redirect condition: `redirect` = `branch_taken` & `valid_ex`.
- Target = `pc_ex` + PC_AHEAD + `InmShifter`, computed modulo 2^32 with wrap-around and no overflow flag. `target[1:0]` is forced to 00.
- Priority per edge: `rst` > `redirect` > `stall` > normal.
- Normal operation:
  - `pc_if` <= `pc_if`+4.
  - `pc_id` <= `pc_if`, `valid_id` <= 1.
  - `pc_ex` <= `pc_id`, `valid_ex` <= `valid_id`.
- Stall:
  - `pc_if`, `pc_id` and `valid_id` hold.
  - `pc_ex` <= `pc_id`, `valid_ex` <= 0 (bubble).
- Redirect:
  - `pc_if` <= target.
  - `valid_id` <= 0, `valid_ex` <= 0.
  - `flush` <= 1.
  - `lr_we` <= `branch_link`, `lr_data` <= `pc_ex`+4.
  - `stall` is ignored on this edge.
- In every other case, `flush` <= 0 and `lr_we` <= 0.
- A `branch_taken` asserted with `valid_ex`=0 (wrong path or bubble) has no effect.
- Effective pipeline state machine, implied by the valid bits: RUN → REDIR1 (EX empty, ID empty) → REDIR2 (EX empty) → RUN. A new redirect cannot occur in REDIR1 or REDIR2 because `valid_ex`=0. A stall during REDIR2 extends the bubble.

## Timing
- Branch seen in EX at edge T:
  - `pc_if`=target and `flush`=1 during cycle T+1.
  - `valid_ex`=0 in cycles T+1 and T+2.
  - The target instruction is in EX with `valid_ex`=1 at cycle T+3, absent stalls. Redirect penalty is 2 cycles.
- `lr_we` and `flush` are high for exactly one cycle, T+1.
- After `rst` is released at edge R:
  - Cycle R: `pc_if`=RESET_VECTOR.
  - Cycle R+1: `valid_id`=1.
  - Cycle R+2: `valid_ex`=1.
- Each stall cycle adds exactly one EX bubble. The PC advance is delayed by exactly one cycle per stall cycle.
- There are no combinational paths from any input to any output.

## Test plan
- Reset then free-run 4 cycles: `pc_if` reads 0, 4, 8, 12. `pc_ex`=0 with `valid_ex`=1 at the 3rd cycle after release.
- Forward branch: `pc_ex`=0x100, `InmShifter`=0x10, `branch_taken`=1 → next cycle `pc_if`=0x118 and `flush`=1. `valid_ex`=0 for 2 cycles, then `pc_ex`=0x118 with `valid_ex`=1.
- Backward branch (Inm24=0xFFFFFE, so `InmShifter`=0xFFFFFFF8): `pc_ex`=0x20 → `pc_if`=0x20, giving a loop that repeats every 3 cycles.
- Wrap-around with link: `pc_ex`=0xFFFFFFF0, `InmShifter`=0x10, `branch_link`=1 → `pc_if`=0x00000008, `lr_we`=1 for one cycle, `lr_data`=0xFFFFFFF4.
- Stall and branch combinations:
  - `stall` for 2 cycles holds `pc_if` and `pc_id` and yields 2 EX bubbles.
  - `stall`=1 and a valid `branch_taken` on the same edge → redirect wins.
  - `branch_taken` with `valid_ex`=0 → no change to `pc_if`.
- `rst` asserted the cycle after a redirect → `pc_if`=RESET_VECTOR, `flush`=0, all valid bits 0 on the next edge.
